i2c_cmd_sequencer: RTL and testbench
====================================

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter PRESCALE, 16'd99, value written to prescale registers at init.
REQ-002 Parameter POLL_LIMIT, 1023, maximum status polls per byte (timeout build only).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  command request.
REQ-006 req_ready  out  1  sequencer idle and accepting.
REQ-007 req_rw  in  1  0 = register write, 1 = register read.
REQ-008 req_dev  in  7  I2C device address.
REQ-009 req_reg  in  8  device register address.
REQ-010 req_wdata  in  8  write data.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  8  read data, held until next resp_valid.
REQ-013 resp_err  out  1  NACK/timeout flag, qualified by resp_valid.
REQ-014 cyc, stb, we  out  1 each  Wishbone master controls.
REQ-015 addr  out  7  Wishbone register address.
REQ-016 dat_o  out  8  Wishbone write data.
REQ-017 dat_i  in  8  Wishbone read data.
REQ-018 ack  in  1  Wishbone acknowledge.

Function
REQ-019 Register map: 0x00 PRER_LO, 0x01 PRER_HI, 0x02 CTR, 0x03 TXR (write) / RXR (read), 0x04 CR (write) / SR (read); SR bit1 = TIP, bit7 = RxACK (1 = NACK).
REQ-020 Wishbone access: cyc=stb=1 with stable we/addr/dat_o until first cycle ack=1; cyc=stb=0 for at least one cycle before the next access; dat_i sampled on the ack cycle.
REQ-021 States: S_INIT, S_IDLE, S_STEP, S_POLL, S_ABORT, S_DONE.
REQ-022 S_INIT writes PRER_LO=PRESCALE[7:0], PRER_HI=PRESCALE[15:8], CTR=0x80, then enters S_IDLE; req_ready=0 throughout.
REQ-023 S_IDLE: req_ready=1; req_valid&req_ready captures all req_* fields into internal registers and enters S_STEP; req_* ignored until the next S_IDLE.
REQ-024 Write sequence: TXR={dev,0}, CR=0x90, poll; TXR=reg, CR=0x10, poll; TXR=wdata, CR=0x50, poll.
REQ-025 Read sequence: TXR={dev,0}, CR=0x90, poll; TXR=reg, CR=0x10, poll; TXR={dev,1}, CR=0x90, poll; CR=0x68, poll; read RXR into resp_rdata.
REQ-026 S_POLL: read SR repeatedly; TIP=1 -> read again; TIP=0 and RxACK=0 -> next step; TIP=0 and RxACK=1 on an address/register/write byte -> S_ABORT. RxACK is ignored after CR=0x68.
REQ-027 S_ABORT: write CR=0x40 (STOP), then S_DONE with resp_err=1; resp_rdata unchanged.
REQ-028 S_DONE: resp_valid=1 for exactly one cycle (resp_err=0 on success), then S_IDLE.
REQ-029 A new request is accepted no earlier than the cycle after resp_valid.
REQ-030 ack arriving while cyc=0 is ignored.

Reset
REQ-031 rst_n low: state=S_INIT, cyc=stb=we=0, addr=0, dat_o=0, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, poll counter=0.
REQ-032 Reset asserted mid-transaction aborts immediately with no STOP issued; init re-runs after release.

Configuration
REQ-033 Macro I2C_SEQ_TIMEOUT_EN defined: poll counter clears at each S_POLL entry and increments per SR read; reaching POLL_LIMIT reads without TIP=0 -> S_ABORT (resp_err=1).
REQ-034 I2C_SEQ_TIMEOUT_EN undefined: no counter logic; S_POLL waits indefinitely.

Verification
REQ-035 Reset release, slave acks in 1 cycle -> writes 0x00=0x63, 0x01=0x00, 0x02=0x80 in order, then req_ready=1.
REQ-036 Write dev=0x50, reg=0x10, data=0xA5, SR=0x00 -> TXR 0xA0, CR 0x90, TXR 0x10, CR 0x10, TXR 0xA5, CR 0x50; resp_valid with resp_err=0.
REQ-037 Read dev=0x50, reg=0x10, RXR=0x3C -> TXR 0xA0/0x10/0xA1, CR 0x90/0x10/0x90/0x68; resp_rdata=0x3C, resp_err=0.
REQ-038 SR=0x80 after address byte -> CR=0x40 written; resp_err=1; no TXR write of reg.
REQ-039 With I2C_SEQ_TIMEOUT_EN and POLL_LIMIT=4, SR stuck 0x02 -> exactly 4 SR reads, CR=0x40, resp_err=1.
REQ-040 rst_n low during S_POLL -> cyc=stb=0 and resp_valid=0 in the same cycle; init sequence repeats after release.

Source files
------------

// File: rtl/i2c_cmd_sequencer.sv
// Register read/write command sequencer driving an OpenCores-style I2C master core over Wishbone.
// Optional SR poll timeout is built when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_cmd_sequencer #(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter int          POLL_LIMIT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       cyc,
  output logic       stb,
  output logic       we,
  output logic [6:0] addr,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack
);

  localparam logic [6:0] A_TXR = 7'h03;  // RXR on read
  localparam logic [6:0] A_CR  = 7'h04;  // SR on read

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_STEP, S_POLL, S_ABORT, S_DONE} state_t;

  state_t     state_reg, state_next;
  logic [2:0] step_reg, step_next;
  logic       cyc_reg, cyc_next;
  logic       we_reg, we_next;
  logic [6:0] addr_reg, addr_next;
  logic [7:0] dat_o_reg, dat_o_next;
  logic       rw_reg, rw_next;
  logic [6:0] dev_reg, dev_next;
  logic [7:0] regad_reg, regad_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] rdata_reg, rdata_next;
  logic       err_reg, err_next;

  logic [6:0] op_addr;
  logic       op_we;
  logic [7:0] op_data;
  logic       op_poll;
  logic       wb_done;
  logic       wb_free;
  logic       bus_state;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(POLL_LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_POLL = CNT_W'(POLL_LIMIT - 1);
  logic [CNT_W-1:0] poll_cnt_reg, poll_cnt_next;
`endif

  assign wb_done   = cyc_reg & ack;
  assign wb_free   = ~cyc_reg;
  assign bus_state = (state_reg == S_INIT) || (state_reg == S_STEP) ||
                     (state_reg == S_POLL) || (state_reg == S_ABORT);

  // Bus operation for the current state/step; steps 0-7 cover both request sequences.
  always_comb begin
    op_addr = A_CR;
    op_we   = 1'b1;
    op_data = 8'h00;
    op_poll = 1'b0;
    case (state_reg)
      S_INIT: begin
        op_addr = {5'd0, step_reg[1:0]};
        case (step_reg[1:0])
          2'd0:    op_data = PRESCALE[7:0];
          2'd1:    op_data = PRESCALE[15:8];
          default: op_data = 8'h80;
        endcase
      end
      S_STEP: begin
        case (step_reg)
          3'd0: begin op_addr = A_TXR; op_data = {dev_reg, 1'b0}; end
          3'd1: begin op_data = 8'h90; op_poll = 1'b1; end
          3'd2: begin op_addr = A_TXR; op_data = regad_reg; end
          3'd3: begin op_data = 8'h10; op_poll = 1'b1; end
          3'd4: begin op_addr = A_TXR; op_data = rw_reg ? {dev_reg, 1'b1} : wdata_reg; end
          3'd5: begin op_data = rw_reg ? 8'h90 : 8'h50; op_poll = 1'b1; end
          3'd6: begin op_data = 8'h68; op_poll = 1'b1; end
          default: begin op_addr = A_TXR; op_we = 1'b0; end
        endcase
      end
      S_POLL:  op_we = 1'b0;
      S_ABORT: op_data = 8'h40;
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    cyc_next   = cyc_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    dat_o_next = dat_o_reg;
    rw_next    = rw_reg;
    dev_next   = dev_reg;
    regad_next = regad_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    err_next   = err_reg;
`ifdef I2C_SEQ_TIMEOUT_EN
    poll_cnt_next = poll_cnt_reg;
`endif

    case (state_reg)
      S_INIT: begin
        if (wb_done) begin
          if (step_reg == 3'd2) begin
            state_next = S_IDLE;
            step_next  = 3'd0;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end
      end
      S_IDLE: begin
        if (req_valid) begin
          rw_next    = req_rw;
          dev_next   = req_dev;
          regad_next = req_reg;
          wdata_next = req_wdata;
          step_next  = 3'd0;
          state_next = S_STEP;
        end
      end
      S_STEP: begin
        if (wb_done) begin
          if (op_poll) begin
            state_next = S_POLL;
`ifdef I2C_SEQ_TIMEOUT_EN
            poll_cnt_next = '0;
`endif
          end else if (step_reg == 3'd7) begin
            rdata_next = dat_i;
            err_next   = 1'b0;
            state_next = S_DONE;
          end else begin
            step_next = step_reg + 3'd1;
          end
        end
      end
      S_POLL: begin
        if (wb_done) begin
`ifdef I2C_SEQ_TIMEOUT_EN
          poll_cnt_next = poll_cnt_reg + 1'b1;
`endif
          if (dat_i[1]) begin
`ifdef I2C_SEQ_TIMEOUT_EN
            if (poll_cnt_reg == LAST_POLL) state_next = S_ABORT;
`endif
          end else if (dat_i[7] && step_reg != 3'd6) begin
            // NACK on address/register/data byte; RxACK after the final read byte is meaningless
            state_next = S_ABORT;
          end else if (!rw_reg && step_reg == 3'd5) begin
            err_next   = 1'b0;
            state_next = S_DONE;
          end else begin
            step_next  = step_reg + 3'd1;
            state_next = S_STEP;
          end
        end
      end
      S_ABORT: begin
        if (wb_done) begin
          err_next   = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase

    // Cycle ends on ack; the next access launches only after one idle cycle.
    if (wb_done) begin
      cyc_next = 1'b0;
    end else if (wb_free && bus_state) begin
      cyc_next   = 1'b1;
      we_next    = op_we;
      addr_next  = op_addr;
      dat_o_next = op_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      step_reg  <= 3'd0;
      cyc_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= 7'd0;
      dat_o_reg <= 8'd0;
      rw_reg    <= 1'b0;
      dev_reg   <= 7'd0;
      regad_reg <= 8'd0;
      wdata_reg <= 8'd0;
      rdata_reg <= 8'd0;
      err_reg   <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_cnt_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      cyc_reg   <= cyc_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      dat_o_reg <= dat_o_next;
      rw_reg    <= rw_next;
      dev_reg   <= dev_next;
      regad_reg <= regad_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      err_reg   <= err_next;
`ifdef I2C_SEQ_TIMEOUT_EN
      poll_cnt_reg <= poll_cnt_next;
`endif
    end
  end

  assign cyc        = cyc_reg;
  assign stb        = cyc_reg;
  assign we         = we_reg;
  assign addr       = addr_reg;
  assign dat_o      = dat_o_reg;
  assign req_ready  = (state_reg == S_IDLE);
  assign resp_valid = (state_reg == S_DONE);
  assign resp_err   = err_reg;
  assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: expected Wishbone accesses and responses are queued
// when each request is driven and compared as the DUT produces them.
module tb_i2c_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev = 7'd0;
  logic [7:0] req_reg = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       cyc, stb, we;
  logic [6:0] addr;
  logic [7:0] dat_o;
  logic [7:0] dat_i = 8'd0;
  logic       ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int resp_count = 0;
  int resp_target = 0;

  logic [15:0] wbq[$];    // {we, addr, data}; data is 0 for reads
  logic [8:0]  respq[$];  // {err, rdata}
  logic [7:0]  sr_q[$];
  logic [7:0]  sr_default = 8'h00;
  logic [7:0]  rxr_val = 8'h00;
  logic [7:0]  model_rdata = 8'h00;

  always #5 clk = ~clk;

  i2c_cmd_sequencer #(.PRESCALE(16'd99), .POLL_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .cyc(cyc), .stb(stb), .we(we), .addr(addr), .dat_o(dat_o),
    .dat_i(dat_i), .ack(ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: acks one cycle after each request; SR values come from sr_q, then sr_default.
  always @(posedge clk) begin
    ack <= 1'b0;
    if (cyc && stb && !ack) begin
      ack <= 1'b1;
      if (!we && addr == 7'h04) begin
        if (sr_q.size() > 0) dat_i <= sr_q.pop_front();
        else dat_i <= sr_default;
      end else if (!we && addr == 7'h03) begin
        dat_i <= rxr_val;
      end else begin
        dat_i <= 8'h00;
      end
    end
  end

  // Bus monitor
  initial begin
    logic        prev_ack;
    logic [15:0] obs, exp;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_ack) check("wb_idle_gap", {31'd0, cyc}, 32'd0);
      prev_ack = cyc && ack;
      if (cyc && stb && ack) begin
        obs = {we, addr, (we ? dat_o : 8'h00)};
        if (wbq.size() == 0) begin
          check("wb_unexpected", {16'd0, obs}, 32'hFFFF_FFFF);
        end else begin
          exp = wbq.pop_front();
          check("wb_access", {16'd0, obs}, {16'd0, exp});
        end
      end
    end
  end

  // Response monitor
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && resp_valid) begin
        resp_count++;
        $display("resp #%0d: err=%0b rdata=0x%02h", resp_count, resp_err, resp_rdata);
        check("ready_low_on_resp", {31'd0, req_ready}, 32'd0);
        if (respq.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp = respq.pop_front();
          check("resp_err", {31'd0, resp_err}, {31'd0, exp[8]});
          check("resp_rdata", {24'd0, resp_rdata}, {24'd0, exp[7:0]});
        end
      end
    end
  end

  task automatic exp_wr(input logic [6:0] a, input logic [7:0] d);
    wbq.push_back({1'b1, a, d});
  endtask

  task automatic exp_rd(input logic [6:0] a);
    wbq.push_back({1'b0, a, 8'h00});
  endtask

  task automatic exp_poll(input int n);
    for (int i = 0; i < n; i++) exp_rd(7'h04);
  endtask

  task automatic exp_init();
    exp_wr(7'h00, 8'h63);
    exp_wr(7'h01, 8'h00);
    exp_wr(7'h02, 8'h80);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_req(input logic rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    wait_ready("req_ready_wait");
    req_valid = 1'b1;
    req_rw    = rw;
    req_dev   = dev;
    req_reg   = rg;
    req_wdata = wd;
    @(negedge clk);
    check("ready_drop_after_accept", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    req_rw    = $urandom_range(0, 1);
    req_dev   = 7'($urandom);
    req_reg   = 8'($urandom);
    req_wdata = 8'($urandom);
    resp_target++;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_count < resp_target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("resp_arrived", {31'd0, (resp_count >= resp_target)}, 32'd1);
  endtask

  task automatic exp_addr_reg(input logic [6:0] dev, input logic [7:0] rg);
    exp_wr(7'h03, {dev, 1'b0}); exp_wr(7'h04, 8'h90); exp_poll(1);
    exp_wr(7'h03, rg);          exp_wr(7'h04, 8'h10); exp_poll(1);
  endtask

  initial begin
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", {31'd0, cyc}, 32'd0);
    check("rst_stb", {31'd0, stb}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_addr", {25'd0, addr}, 32'd0);
    check("rst_dat_o", {24'd0, dat_o}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", {24'd0, resp_rdata}, 32'd0);

    // Init sequence after release
    exp_init();
    rst_n = 1'b1;
    wait_ready("init_ready");
    check("init_all_seen", wbq.size(), 32'd0);

    // Register write
    exp_addr_reg(7'h50, 8'h10);
    exp_wr(7'h03, 8'hA5); exp_wr(7'h04, 8'h50); exp_poll(1);
    respq.push_back({1'b0, model_rdata});
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_resp();

    // Register read
    rxr_val = 8'h3C;
    exp_addr_reg(7'h50, 8'h10);
    exp_wr(7'h03, 8'hA1); exp_wr(7'h04, 8'h90); exp_poll(1);
    exp_wr(7'h04, 8'h68); exp_poll(1);
    exp_rd(7'h03);
    model_rdata = 8'h3C;
    respq.push_back({1'b0, model_rdata});
    do_req(1'b1, 7'h50, 8'h10, 8'h00);
    wait_resp();

    // NACK on address byte: STOP, error, rdata kept
    sr_q.push_back(8'h80);
    exp_wr(7'h03, 8'hA0); exp_wr(7'h04, 8'h90); exp_poll(1);
    exp_wr(7'h04, 8'h40);
    respq.push_back({1'b1, model_rdata});
    do_req(1'b0, 7'h50, 8'h10, 8'h77);
    wait_resp();

    // TIP busy for two polls before the address byte completes
    sr_q.push_back(8'h02); sr_q.push_back(8'h02);
    exp_wr(7'h03, 8'h42); exp_wr(7'h04, 8'h90); exp_poll(3);
    exp_wr(7'h03, 8'h07); exp_wr(7'h04, 8'h10); exp_poll(1);
    exp_wr(7'h03, 8'h5A); exp_wr(7'h04, 8'h50); exp_poll(1);
    respq.push_back({1'b0, model_rdata});
    do_req(1'b0, 7'h21, 8'h07, 8'h5A);
    wait_resp();

    // Read where RxACK=1 after the final read byte must be ignored
    rxr_val = 8'h99;
    sr_q.push_back(8'h00); sr_q.push_back(8'h00); sr_q.push_back(8'h00); sr_q.push_back(8'h80);
    exp_addr_reg(7'h33, 8'h44);
    exp_wr(7'h03, 8'h67); exp_wr(7'h04, 8'h90); exp_poll(1);
    exp_wr(7'h04, 8'h68); exp_poll(1);
    exp_rd(7'h03);
    model_rdata = 8'h99;
    respq.push_back({1'b0, model_rdata});
    do_req(1'b1, 7'h33, 8'h44, 8'h00);
    wait_resp();

`ifdef I2C_SEQ_TIMEOUT_EN
    // SR stuck busy: exactly POLL_LIMIT reads, then STOP
    sr_default = 8'h02;
    exp_wr(7'h03, 8'h20); exp_wr(7'h04, 8'h90); exp_poll(4);
    exp_wr(7'h04, 8'h40);
    respq.push_back({1'b1, model_rdata});
    do_req(1'b0, 7'h10, 8'h01, 8'h02);
    wait_resp();
    sr_default = 8'h00;
`endif

    // Reset while polling: bus drops at once, no STOP, init repeats
    check("queues_empty_before_rst", wbq.size() + respq.size(), 32'd0);
    sr_default = 8'h02;
    exp_wr(7'h03, 8'hA0); exp_wr(7'h04, 8'h90);
    do_req(1'b0, 7'h50, 8'h10, 8'h11);
    resp_target--;
    n = 0;
    while (!(cyc && !we && addr == 7'h04 && !ack) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_poll", {31'd0, (cyc && !we && addr == 7'h04)}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_cyc", {31'd0, cyc}, 32'd0);
    check("midrst_stb", {31'd0, stb}, 32'd0);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst_wb_seen", wbq.size(), 32'd0);
    repeat (2) @(negedge clk);
    sr_default = 8'h00;
    exp_init();
    rst_n = 1'b1;
    wait_ready("reinit_ready");
    check("reinit_all_seen", wbq.size(), 32'd0);

    // Normal write after re-init
    exp_addr_reg(7'h0F, 8'hF0);
    exp_wr(7'h03, 8'h3C); exp_wr(7'h04, 8'h50); exp_poll(1);
    respq.push_back({1'b0, 8'h00});
    do_req(1'b0, 7'h0F, 8'hF0, 8'h3C);
    wait_resp();

    repeat (3) @(negedge clk);
    check("wb_queue_left", wbq.size(), 32'd0);
    check("resp_queue_left", respq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
